// File: rtl/cmd_resp_pkg.sv
// Shared types and constants for the command responder: FSM states, reply strings, terminator.
package cmd_resp_pkg;

  typedef enum logic [1:0] {RCV, LOAD, SEND, DONE} resp_state_t;

  localparam int              REPLY_LEN = 5;
  localparam logic [7:0]      TERM_DEF  = 8'h0D;
  // Element 0 is the first byte on the wire.
  localparam logic [0:4][7:0] AOK_STR   = {8'h41, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
  localparam logic [0:4][7:0] ERR_STR   = {8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};

  function automatic logic [7:0] reply_byte(input logic good, input logic [2:0] idx);
    return good ? AOK_STR[idx] : ERR_STR[idx];
  endfunction

endpackage

// File: rtl/cmd_responder_uart.sv
// 8N1 UART: oversampling-free receiver (mid-bit sample) and shift-register transmitter.
module cmd_responder_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rx_rdy
);

  localparam int CW = $clog2(BAUD_DIV);

  // ---------------- receiver ----------------
  logic          rx_ff1, rx_s, rx_on;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [8:0]    rx_shft;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_on   <= 1'b0;
      rx_baud <= '0;
      rx_bits <= '0;
      rx_shft <= '0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_on) begin
        if (!rx_s) begin
          // first sample lands mid start bit, then one per bit period
          rx_on   <= 1'b1;
          rx_baud <= CW'(BAUD_DIV/2 - 1);
          rx_bits <= '0;
        end
      end else if (rx_baud == '0) begin
        rx_shft <= {rx_s, rx_shft[8:1]};
        rx_baud <= CW'(BAUD_DIV - 1);
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits == 4'd9) begin
          rx_on  <= 1'b0;
          rx_rdy <= 1'b1;
        end
      end else begin
        rx_baud <= rx_baud - 1'b1;
      end
    end
  end

  // after the stop sample the 8 data bits sit below it
  assign rx_data = rx_shft[7:0];

  // ---------------- transmitter ----------------
  logic          tx_on;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_shft;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_on   <= 1'b0;
      tx_baud <= '0;
      tx_bits <= '0;
      tx_shft <= '1;
      tx_done <= 1'b0;
      TX      <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      TX      <= tx_shft[0];
      if (trmt) begin
        tx_shft <= {1'b1, tx_data, 1'b0};
        tx_baud <= CW'(BAUD_DIV - 1);
        tx_bits <= '0;
        tx_on   <= 1'b1;
        TX      <= 1'b0;
      end else if (tx_on) begin
        if (tx_baud == '0) begin
          tx_shft <= {1'b1, tx_shft[9:1]};
          tx_baud <= CW'(BAUD_DIV - 1);
          TX      <= tx_shft[1];
          if (tx_bits == 4'd9) begin
            tx_on   <= 1'b0;
            tx_done <= 1'b1;
            TX      <= 1'b1;
          end else begin
            tx_bits <= tx_bits + 4'd1;
          end
        end else begin
          tx_baud <= tx_baud - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmd_responder.sv
// Line-buffering command responder: collects bytes up to TERM, replies AOK/ERR on TX,
// and exposes good lines to the host through cmd_rdy/cmd_len/rd_addr/rd_data.
module cmd_responder
  import cmd_resp_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] TERM     = TERM_DEF,
  parameter int         BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       cmd_rdy,
  output logic [3:0] cmd_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_P = 5'(DEPTH);

  resp_state_t state, state_nxt;
  logic [4:0]  wr_ptr, wr_ptr_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        good, good_nxt, ovf, ovf_nxt;
  logic        cmd_rdy_nxt;
  logic [3:0]  cmd_len_nxt;
  logic        buf_we, trmt, tx_done, rx_rdy;
  logic [7:0]  rx_data, tx_data;
  logic [7:0]  buf_mem [DEPTH];

  cmd_responder_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .TX        (TX),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .clr_rx_rdy(rx_rdy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RCV;
      wr_ptr  <= '0;
      idx     <= '0;
      good    <= 1'b0;
      ovf     <= 1'b0;
      cmd_rdy <= 1'b0;
      cmd_len <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      idx     <= idx_nxt;
      good    <= good_nxt;
      ovf     <= ovf_nxt;
      cmd_rdy <= cmd_rdy_nxt;
      cmd_len <= cmd_len_nxt;
    end
  end

  // Buffer contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  assign rd_data = buf_mem[rd_addr[AW-1:0]];
  assign busy    = (state != RCV);
  // idx_nxt selects the byte being launched, so data is valid alongside trmt
  assign tx_data = reply_byte(good, idx_nxt);

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    idx_nxt     = idx;
    good_nxt    = good;
    ovf_nxt     = ovf;
    cmd_rdy_nxt = 1'b0;
    cmd_len_nxt = cmd_len;
    buf_we      = 1'b0;
    trmt        = 1'b0;
    case (state)
      RCV: begin
        if (rx_rdy) begin
          if (rx_data == TERM) begin
            good_nxt  = (wr_ptr != '0) & ~ovf;
            state_nxt = LOAD;
          end else if (wr_ptr < DEPTH_P) begin
            buf_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 5'd1;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        trmt      = 1'b1;
        idx_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (tx_done) begin
          if (idx != 3'(REPLY_LEN - 1)) begin
            idx_nxt = idx + 3'd1;
            trmt    = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (good) begin
          cmd_rdy_nxt = 1'b1;
          cmd_len_nxt = wr_ptr[3:0];
        end
        wr_ptr_nxt = '0;
        ovf_nxt    = 1'b0;
        state_nxt  = RCV;
      end
      default: state_nxt = RCV;
    endcase
  end

endmodule
